// File: rtl/sync_fifo_flagged.sv
// -----------------------------------------------------------------------------
// sync_fifo_flagged
//   Parametrised single-clock circular FIFO with occupancy count, almost-full /
//   almost-empty thresholds, optional first-word-fall-through read mode and
//   sticky overflow/underflow error flags.
//
// Ports
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   enable          global enable; low freezes all state
//   wr_en, wr_data  write request and data
//   rd_en           read request (FWFT=1: pop the presented head word)
//   rd_data         read data
//   rd_valid        FWFT=0: one-cycle pulse after an accepted read
//                   FWFT=1: head word present (not empty)
//   full, empty     count == DEPTH / count == 0
//   almost_full     count >= AF_THRESH
//   almost_empty    count <= AE_THRESH
//   count           occupancy 0..DEPTH
//   overflow        sticky: write rejected while full
//   underflow       sticky: read rejected while empty
//   clr_err         synchronous clear of overflow/underflow
// -----------------------------------------------------------------------------
module sync_fifo_flagged #(
   parameter int DATA_W    = 8,
   parameter int DEPTH     = 16,
   parameter int AF_THRESH = DEPTH - 2,
   parameter int AE_THRESH = 2,
   parameter int FWFT      = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     enable,
   input  logic                     wr_en,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     rd_en,
   output logic [DATA_W-1:0]        rd_data,
   output logic                     rd_valid,
   output logic                     full,
   output logic                     empty,
   output logic                     almost_full,
   output logic                     almost_empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic                     underflow,
   input  logic                     clr_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
   localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              overflow_q, overflow_d;
   logic              underflow_q, underflow_d;
   logic              rd_acc, wr_acc;

   // Flags decode the registered count only.
   assign full         = (count_q == DEPTH_C);
   assign empty        = (count_q == '0);
   assign almost_full  = (count_q >= AF_C);
   assign almost_empty = (count_q <= AE_C);
   assign count        = count_q;
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

   // A write into a full FIFO is accepted only alongside an accepted read.
   assign rd_acc = enable & rd_en & ~empty;
   assign wr_acc = enable & wr_en & (~full | rd_acc);

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;

      if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);

      case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      // Error set takes priority over clear.
      if (enable) begin
         if (wr_en & ~wr_acc)  overflow_d  = 1'b1;
         else if (clr_err)     overflow_d  = 1'b0;
         if (rd_en & ~rd_acc)  underflow_d = 1'b1;
         else if (clr_err)     underflow_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage is not reset; entries are always written before being read.
   always_ff @(posedge clk) begin
      if (wr_acc) mem_q[wr_ptr_q] <= wr_data;
   end

   generate
      if (FWFT != 0) begin : g_fwft
         // Head word is only meaningful when non-empty; present zero otherwise
         // so the output is defined out of reset.
         assign rd_data  = empty ? '0 : mem_q[rd_ptr_q];
         assign rd_valid = ~empty;
      end else begin : g_reg
         logic [DATA_W-1:0] rd_data_q;
         logic              rd_valid_q;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               rd_data_q  <= '0;
               rd_valid_q <= 1'b0;
            end else begin
               rd_valid_q <= rd_acc;
               if (rd_acc) rd_data_q <= mem_q[rd_ptr_q];
            end
         end

         assign rd_data  = rd_data_q;
         assign rd_valid = rd_valid_q;
      end
   endgenerate

endmodule

// File: tb/tb_sync_fifo_flagged.sv
module tb_sync_fifo_flagged;

   localparam int DW = 8;
   localparam int DP = 16;
   localparam int AF = 14;
   localparam int AE = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;

   // Registered-read instance
   logic          en0 = 1'b1, we0 = 1'b0, re0 = 1'b0, ce0 = 1'b0;
   logic [DW-1:0] wd0 = '0;
   logic [DW-1:0] rd0;
   logic          rv0, full0, empty0, af0, ae0, ovf0, unf0;
   logic [4:0]    cnt0;

   // First-word-fall-through instance
   logic          en1 = 1'b1, we1 = 1'b0, re1 = 1'b0, ce1 = 1'b0;
   logic [DW-1:0] wd1 = '0;
   logic [DW-1:0] rd1;
   logic          rv1, full1, empty1, af1, ae1, ovf1, unf1;
   logic [4:0]    cnt1;

   int total = 0;
   int bad   = 0;

   // Reference model state
   logic [DW-1:0] q0[$];
   logic [DW-1:0] q1[$];
   logic [DW-1:0] m_rd0 = '0;
   bit            m_ovf0 = 0, m_unf0 = 0, m_ovf1 = 0, m_unf1 = 0;

   always #5 clk = ~clk;

   sync_fifo_flagged #(.DATA_W(DW), .DEPTH(DP), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0)) dut0 (
      .clk(clk), .rst(rst), .enable(en0), .wr_en(we0), .wr_data(wd0), .rd_en(re0),
      .rd_data(rd0), .rd_valid(rv0), .full(full0), .empty(empty0),
      .almost_full(af0), .almost_empty(ae0), .count(cnt0),
      .overflow(ovf0), .underflow(unf0), .clr_err(ce0));

   sync_fifo_flagged #(.DATA_W(DW), .DEPTH(DP), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1)) dut1 (
      .clk(clk), .rst(rst), .enable(en1), .wr_en(we1), .wr_data(wd1), .rd_en(re1),
      .rd_data(rd1), .rd_valid(rv1), .full(full1), .empty(empty1),
      .almost_full(af1), .almost_empty(ae1), .count(cnt1),
      .overflow(ovf1), .underflow(unf1), .clr_err(ce1));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_vals();
      check("rst_count",  32'(cnt0), 0);
      check("rst_empty",  32'(empty0), 1);
      check("rst_full",   32'(full0), 0);
      check("rst_ae",     32'(ae0), 1);
      check("rst_af",     32'(af0), 0);
      check("rst_rdata",  32'(rd0), 0);
      check("rst_rvalid", 32'(rv0), 0);
      check("rst_ovf",    32'(ovf0), 0);
      check("rst_unf",    32'(unf0), 0);
      check("rst1_empty", 32'(empty1), 1);
      check("rst1_rvalid",32'(rv1), 0);
      check("rst1_rdata", 32'(rd1), 0);
   endtask

   task automatic model_reset();
      q0.delete(); q1.delete();
      m_rd0 = '0;
      m_ovf0 = 0; m_unf0 = 0; m_ovf1 = 0; m_unf1 = 0;
   endtask

   // One clock of the registered-read FIFO against the queue model.
   task automatic cycle0(input bit we, input logic [DW-1:0] wd, input bit re,
                         input bit en, input bit ce);
      bit racc, wacc;
      int n;
      racc = en && re && (q0.size() != 0);
      wacc = en && we && ((q0.size() != DP) || racc);
      if (racc) m_rd0 = q0.pop_front();
      if (wacc) q0.push_back(wd);
      if (en && we && !wacc) m_ovf0 = 1; else if (en && ce) m_ovf0 = 0;
      if (en && re && !racc) m_unf0 = 1; else if (en && ce) m_unf0 = 0;
      we0 = we; wd0 = wd; re0 = re; en0 = en; ce0 = ce;
      @(posedge clk); #1;
      n = q0.size();
      check("count",  32'(cnt0),   32'(n));
      check("empty",  32'(empty0), 32'(n == 0));
      check("full",   32'(full0),  32'(n == DP));
      check("afull",  32'(af0),    32'(n >= AF));
      check("aempty", 32'(ae0),    32'(n <= AE));
      check("rvalid", 32'(rv0),    32'(racc));
      check("rdata",  32'(rd0),    32'(m_rd0));
      check("ovf",    32'(ovf0),   32'(m_ovf0));
      check("unf",    32'(unf0),   32'(m_unf0));
   endtask

   // One clock of the FWFT FIFO against its queue model.
   task automatic cycle1(input bit we, input logic [DW-1:0] wd, input bit re,
                         input bit en, input bit ce);
      bit racc, wacc;
      int n;
      racc = en && re && (q1.size() != 0);
      wacc = en && we && ((q1.size() != DP) || racc);
      if (racc) void'(q1.pop_front());
      if (wacc) q1.push_back(wd);
      if (en && we && !wacc) m_ovf1 = 1; else if (en && ce) m_ovf1 = 0;
      if (en && re && !racc) m_unf1 = 1; else if (en && ce) m_unf1 = 0;
      we1 = we; wd1 = wd; re1 = re; en1 = en; ce1 = ce;
      @(posedge clk); #1;
      n = q1.size();
      check("f_count",  32'(cnt1),   32'(n));
      check("f_empty",  32'(empty1), 32'(n == 0));
      check("f_full",   32'(full1),  32'(n == DP));
      check("f_rvalid", 32'(rv1),    32'(n != 0));
      if (n != 0) check("f_rdata", 32'(rd1), 32'(q1[0]));
      check("f_ovf",    32'(ovf1),   32'(m_ovf1));
      check("f_unf",    32'(unf1),   32'(m_unf1));
   endtask

   initial begin
      // Reset state
      #1;
      check_reset_vals();
      #11 rst = 1'b0;

      // Fill 0x01..0x10, overflow attempt, drain in order
      for (int i = 1; i <= DP; i++) cycle0(1, 8'(i), 0, 1, 0);
      cycle0(1, 8'hEE, 0, 1, 0);
      for (int i = 0; i < DP; i++) cycle0(0, 8'h00, 1, 1, 0);
      cycle0(0, 8'h00, 0, 1, 1);

      // Wrap-around across pointer 15 -> 0
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 12; i++) cycle0(1, 8'(8'h40 + r*16 + i), 0, 1, 0);
         for (int i = 0; i < 12; i++) cycle0(0, 8'h00, 1, 1, 0);
      end

      // Full with simultaneous read+write, then empty with simultaneous
      for (int i = 0; i < DP; i++) cycle0(1, 8'(8'h80 + i), 0, 1, 0);
      cycle0(1, 8'hC3, 1, 1, 0);
      for (int i = 0; i < DP; i++) cycle0(0, 8'h00, 1, 1, 0);
      cycle0(1, 8'h5A, 1, 1, 0);

      // Enable low with both requests asserted
      for (int i = 0; i < 5; i++) cycle0(1, 8'hFF, 1, 0, 0);
      cycle0(0, 8'h00, 1, 1, 1);

      // Randomized traffic, write-heavy then read-heavy
      for (int i = 0; i < 250; i++)
         cycle0($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 9) < 4,
                $urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0);
      for (int i = 0; i < 250; i++)
         cycle0($urandom_range(0, 9) < 4, 8'($urandom), $urandom_range(0, 9) < 7,
                $urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0);

      // FWFT: word written into empty is presented without a read request
      cycle1(1, 8'hA5, 0, 1, 0);
      check("f_a5_valid", 32'(rv1), 1);
      check("f_a5_data",  32'(rd1), 32'h A5);
      cycle1(0, 8'h00, 0, 1, 0);
      cycle1(0, 8'h00, 1, 1, 0);
      check("f_pop_empty", 32'(empty1), 1);
      for (int i = 0; i < 250; i++)
         cycle1($urandom_range(0, 9) < 5, 8'($urandom), $urandom_range(0, 9) < 5,
                $urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0);

      // Asynchronous reset with data queued and overflow set
      cycle0(0, 8'h00, 1, 1, 1);
      while (q0.size() != 0) cycle0(0, 8'h00, 1, 1, 0);
      for (int i = 0; i < DP; i++) cycle0(1, 8'(8'h10 + i), 0, 1, 0);
      cycle0(1, 8'h99, 0, 1, 0);
      for (int i = 0; i < 9; i++) cycle0(0, 8'h00, 1, 1, 0);
      check("pre_rst_count", 32'(cnt0), 7);
      check("pre_rst_ovf",   32'(ovf0), 1);
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_reset_vals();
      #2 rst = 1'b0;
      cycle0(0, 8'h00, 1, 1, 0);
      check("post_rst_unf", 32'(unf0), 1);
      cycle0(0, 8'h00, 0, 1, 1);
      check("clr_unf", 32'(unf0), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
